// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: 8-bit HD44780 write-only sequencer.
// Runs the power-up init sequence, then drains a small command/data FIFO,
// generating setup / enable / hold timing and per-command execution waits.
module lcd_hd44780_ctrl #(
   parameter int POWERUP_CYC  = 750000,
   parameter int SETUP_CYC    = 4,
   parameter int EN_CYC       = 25,
   parameter int HOLD_CYC     = 4,
   parameter int CMD_WAIT_CYC = 2000,
   parameter int CLR_WAIT_CYC = 82000,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_CYC = max_i(max_i(max_i(POWERUP_CYC, SETUP_CYC), max_i(EN_CYC, HOLD_CYC)),
                                  max_i(CMD_WAIT_CYC, CLR_WAIT_CYC));
   localparam int CNT_W = $clog2(MAX_CYC + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_PWRUP = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_IDLE  = 3'd5
   } state_t;

   // Init ROM: function set (x3), display on, clear, entry mode.
   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    return 8'h38;
         3'd1:    return 8'h38;
         3'd2:    return 8'h38;
         3'd3:    return 8'h0C;
         3'd4:    return 8'h01;
         3'd5:    return 8'h06;
         default: return 8'h00;
      endcase
   endfunction

   // Clear display / return home need the long execution wait.
   function automatic logic is_clr_home(input logic rs, input logic [7:0] d);
      return (rs == 1'b0) && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03));
   endfunction

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       init_idx_r;
   logic             init_done_r;
   logic             lcd_rs_r;
   logic             lcd_en_r;
   logic [7:0]       lcd_data_r;

   logic [8:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [LVL_W-1:0] level_r;

   logic             push_s;
   logic             pop_s;
   logic [8:0]       head_s;

   assign wr_ready  = (level_r != LVL_FULL);
   assign push_s    = wr_valid && wr_ready;
   assign pop_s     = (state_r == ST_IDLE) && (level_r != LVL_W'(0));
   assign head_s    = mem_r[rd_ptr_r];

   assign init_done = init_done_r;
   assign busy      = !(init_done_r && (level_r == LVL_W'(0)) && (state_r == ST_IDLE));
   assign lcd_rs    = lcd_rs_r;
   assign lcd_rw    = 1'b0;
   assign lcd_en    = lcd_en_r;
   assign lcd_data  = lcd_data_r;

   // FIFO storage: payload only, validity is tracked by the pointers.
   always_ff @(posedge clk_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {wr_rs, wr_data};
      end
   end

   // FIFO pointers and fill level; simultaneous push and pop keep the level.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         if (push_s && !pop_s) begin
            level_r <= level_r + LVL_W'(1);
         end else if (pop_s && !push_s) begin
            level_r <= level_r - LVL_W'(1);
         end else begin
            level_r <= level_r;
         end
      end
   end

   // Transfer sequencer: power-up delay, init ROM, then FIFO bytes.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_r     <= ST_PWRUP;
         cnt_r       <= {CNT_W{1'b0}};
         init_idx_r  <= 3'd0;
         init_done_r <= 1'b0;
         lcd_rs_r    <= 1'b0;
         lcd_en_r    <= 1'b0;
         lcd_data_r  <= 8'h00;
      end else begin
         case (state_r)
            ST_PWRUP: begin
               // counts up from its reset value of zero
               if (cnt_r == PWR_LD) begin
                  state_r    <= ST_SETUP;
                  cnt_r      <= SETUP_LD;
                  init_idx_r <= 3'd0;
                  lcd_rs_r   <= 1'b0;
                  lcd_data_r <= init_byte(3'd0);
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_IDLE: begin
               if (pop_s) begin
                  state_r    <= ST_SETUP;
                  cnt_r      <= SETUP_LD;
                  lcd_rs_r   <= head_s[8];
                  lcd_data_r <= head_s[7:0];
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               if (cnt_r == CNT_W'(0)) begin
                  state_r  <= ST_PULSE;
                  cnt_r    <= EN_LD;
                  lcd_en_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_PULSE: begin
               if (cnt_r == CNT_W'(0)) begin
                  state_r  <= ST_HOLD;
                  cnt_r    <= HOLD_LD;
                  lcd_en_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_r == CNT_W'(0)) begin
                  state_r <= ST_WAIT;
                  cnt_r   <= is_clr_home(lcd_rs_r, lcd_data_r) ? CLR_LD : CMD_LD;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (cnt_r != CNT_W'(0)) begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end else if (init_done_r) begin
                  state_r <= ST_IDLE;
               end else if (init_idx_r == 3'd5) begin
                  init_done_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r    <= ST_SETUP;
                  cnt_r      <= SETUP_LD;
                  init_idx_r <= init_idx_r + 3'd1;
                  lcd_rs_r   <= 1'b0;
                  lcd_data_r <= init_byte(init_idx_r + 3'd1);
               end
            end
            default: begin
               state_r  <= ST_PWRUP;
               cnt_r    <= {CNT_W{1'b0}};
               lcd_en_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
